// File: rtl/dig_out_port.sv
// Bus-mapped digital output port: three 8-bit registers (A/B/C) driving parallel
// outputs, with a one-transfer-per-two-cycles strobe/ack handshake.
module dig_out_port #(
    parameter logic [7:0] REGION = 8'h02,
    parameter logic [7:0] OFS_A  = 8'h00,
    parameter logic [7:0] OFS_B  = 8'h10,
    parameter logic [7:0] OFS_C  = 8'h20
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [31:0] iADR,
    input  logic [31:0] iDAT,
    output logic [31:0] oDAT,
    input  logic        iWE,
    input  logic        iSTB,
    output logic        oACK,
    output logic [7:0]  oDOUTA,
    output logic [7:0]  oDOUTB,
    output logic [7:0]  oDOUTC
);

    logic       selS;
    logic       acceptS;
    logic       hitAS;
    logic       hitBS;
    logic       hitCS;
    logic [7:0] rdMuxS;
    logic       ackR;
    logic [31:0] datR;
    logic [7:0] regAR;
    logic [7:0] regBR;
    logic [7:0] regCR;

    // The register map aliases across the region, so the middle address bits
    // and the upper data bits are deliberately ignored.
    logic unusedBits;
    assign unusedBits = ^{iDAT[31:8], iADR[23:8]};

    // Block select and accept: a held strobe is accepted only while no ack is pending.
    always_comb begin
        selS    = iSTB && (iADR[31:24] == REGION);
        acceptS = selS && !ackR;
    end

    // Offset decode and read-data mux; unmapped offsets read as zero.
    always_comb begin
        hitAS  = 1'b0;
        hitBS  = 1'b0;
        hitCS  = 1'b0;
        rdMuxS = 8'h00;
        if (iADR[7:0] == OFS_A) begin
            hitAS  = 1'b1;
            rdMuxS = regAR;
        end else if (iADR[7:0] == OFS_B) begin
            hitBS  = 1'b1;
            rdMuxS = regBR;
        end else if (iADR[7:0] == OFS_C) begin
            hitCS  = 1'b1;
            rdMuxS = regCR;
        end else begin
            rdMuxS = 8'h00;
        end
    end

    // Handshake, read data and output registers; all updates happen on an accept edge.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            ackR  <= 1'b0;
            datR  <= 32'h0000_0000;
            regAR <= 8'h00;
            regBR <= 8'h00;
            regCR <= 8'h00;
        end else begin
            ackR <= acceptS;
            // oDAT is cleared every cycle except the one following an accepted read.
            if (acceptS && !iWE) begin
                datR <= {24'h00_0000, rdMuxS};
            end else begin
                datR <= 32'h0000_0000;
            end
            if (acceptS && iWE && hitAS) begin
                regAR <= iDAT[7:0];
            end else begin
                regAR <= regAR;
            end
            if (acceptS && iWE && hitBS) begin
                regBR <= iDAT[7:0];
            end else begin
                regBR <= regBR;
            end
            if (acceptS && iWE && hitCS) begin
                regCR <= iDAT[7:0];
            end else begin
                regCR <= regCR;
            end
        end
    end

    assign oACK   = ackR;
    assign oDAT   = datR;
    assign oDOUTA = regAR;
    assign oDOUTB = regBR;
    assign oDOUTC = regCR;

endmodule

// File: tb/tb_dig_out_port.sv
// Scoreboard bench for dig_out_port: stimulus queues the expected ack response,
// a negedge monitor compares every ack and checks oDAT is zero between acks.
module tb_dig_out_port;

    logic        iCLK;
    logic        iRST;
    logic [31:0] iADR;
    logic [31:0] iDAT;
    logic [31:0] oDAT;
    logic        iWE;
    logic        iSTB;
    logic        oACK;
    logic [7:0]  oDOUTA;
    logic [7:0]  oDOUTB;
    logic [7:0]  oDOUTC;

    typedef struct {
        logic [31:0] dat;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  c;
    } exp_t;

    exp_t expQ[$];
    int   checks;
    int   errors;

    dig_out_port dut (
        .iCLK   (iCLK),
        .iRST   (iRST),
        .iADR   (iADR),
        .iDAT   (iDAT),
        .oDAT   (oDAT),
        .iWE    (iWE),
        .iSTB   (iSTB),
        .oACK   (oACK),
        .oDOUTA (oDOUTA),
        .oDOUTB (oDOUTB),
        .oDOUTC (oDOUTC)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every ack pops one expected response; between acks oDAT must be zero.
    always @(negedge iCLK) begin
        exp_t e;
        if (iRST) begin
            if (oACK) begin
                if (expQ.size() == 0) begin
                    chk("unexpected_ack", {31'd0, oACK}, 32'd0);
                end else begin
                    e = expQ.pop_front();
                    chk("ack_dat", oDAT, e.dat);
                    chk("ack_doutA", {24'd0, oDOUTA}, {24'd0, e.a});
                    chk("ack_doutB", {24'd0, oDOUTB}, {24'd0, e.b});
                    chk("ack_doutC", {24'd0, oDOUTC}, {24'd0, e.c});
                end
            end else begin
                chk("idle_dat", oDAT, 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge iCLK);
        #2;
    endtask

    // One strobe cycle followed by an idle cycle.
    task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input bit expAck, input logic [31:0] expDat,
                        input logic [7:0] ea, input logic [7:0] eb, input logic [7:0] ec);
        exp_t e;
        iSTB = 1'b1;
        iWE  = we;
        iADR = adr;
        iDAT = dat;
        if (expAck) begin
            e.dat = expDat;
            e.a = ea;
            e.b = eb;
            e.c = ec;
            expQ.push_back(e);
        end
        tick();
        if (!expAck) begin
            chk("no_ack", {31'd0, oACK}, 32'd0);
        end
        iSTB = 1'b0;
        iWE  = 1'b0;
        iADR = 32'd0;
        iDAT = 32'd0;
        tick();
        if (!expAck) begin
            chk("no_ack_douts", {8'd0, oDOUTA, oDOUTB, oDOUTC}, {8'd0, ea, eb, ec});
        end
    endtask

    initial begin
        exp_t e;
        logic [3:0] pat;
        checks = 0;
        errors = 0;
        iRST = 1'b0;
        iSTB = 1'b0;
        iWE  = 1'b0;
        iADR = 32'd0;
        iDAT = 32'd0;
        #12 iRST = 1'b1;
        tick();
        tick();
        chk("rst_ack", {31'd0, oACK}, 32'd0);
        chk("rst_dat", oDAT, 32'd0);
        chk("rst_douts", {8'd0, oDOUTA, oDOUTB, oDOUTC}, 32'd0);

        // Writes to A/B/C
        xfer(1'b1, 32'h0200_0000, 32'h0000_0012, 1'b1, 32'd0, 8'h12, 8'h00, 8'h00);
        xfer(1'b1, 32'h0200_0010, 32'h0000_0034, 1'b1, 32'd0, 8'h12, 8'h34, 8'h00);
        xfer(1'b1, 32'h0200_0020, 32'hFFFF_FF56, 1'b1, 32'd0, 8'h12, 8'h34, 8'h56);
        // Reads, including an aliased address
        xfer(1'b0, 32'h0200_0000, 32'd0, 1'b1, 32'h12, 8'h12, 8'h34, 8'h56);
        xfer(1'b0, 32'h0200_0010, 32'd0, 1'b1, 32'h34, 8'h12, 8'h34, 8'h56);
        xfer(1'b0, 32'h0200_0020, 32'd0, 1'b1, 32'h56, 8'h12, 8'h34, 8'h56);
        xfer(1'b0, 32'h02AB_CD10, 32'd0, 1'b1, 32'h34, 8'h12, 8'h34, 8'h56);
        // Other region, then unmapped offset
        xfer(1'b1, 32'h0100_0000, 32'h0000_00FF, 1'b0, 32'd0, 8'h12, 8'h34, 8'h56);
        xfer(1'b1, 32'h0200_0030, 32'h0000_0077, 1'b1, 32'd0, 8'h12, 8'h34, 8'h56);
        xfer(1'b0, 32'h0200_0030, 32'd0, 1'b1, 32'd0, 8'h12, 8'h34, 8'h56);

        // Strobe held for four edges: ack on alternate cycles
        pat = 4'b1010;
        e.dat = 32'd0;
        e.a = 8'hAA;
        e.b = 8'h34;
        e.c = 8'h56;
        expQ.push_back(e);
        expQ.push_back(e);
        iSTB = 1'b1;
        iWE  = 1'b1;
        iADR = 32'h0200_0000;
        iDAT = 32'h0000_00AA;
        for (int i = 0; i < 4; i++) begin
            @(negedge iCLK);
            chk("held_ack_pattern", {31'd0, oACK}, {31'd0, pat[i]});
        end
        tick();
        iSTB = 1'b0;
        iWE  = 1'b0;
        tick();
        chk("held_doutA", {24'd0, oDOUTA}, 32'h0000_00AA);

        // Reset mid-transfer: ack of a read in flight, write strobe pending
        iSTB = 1'b1;
        iWE  = 1'b0;
        iADR = 32'h0200_0000;
        tick();
        iWE  = 1'b1;
        iADR = 32'h0200_0010;
        iDAT = 32'h0000_0099;
        #1;
        chk("pre_rst_ack", {31'd0, oACK}, 32'd1);
        iRST = 1'b0;
        #1;
        chk("async_rst_ack", {31'd0, oACK}, 32'd0);
        chk("async_rst_dat", oDAT, 32'd0);
        chk("async_rst_douts", {8'd0, oDOUTA, oDOUTB, oDOUTC}, 32'd0);
        tick();
        chk("rst_hold_doutB", {24'd0, oDOUTB}, 32'd0);
        iSTB = 1'b0;
        iWE  = 1'b0;
        iRST = 1'b1;
        // First accept right after release, then confirm B was never written
        xfer(1'b1, 32'h0200_0000, 32'h0000_005A, 1'b1, 32'd0, 8'h5A, 8'h00, 8'h00);
        xfer(1'b0, 32'h0200_0010, 32'd0, 1'b1, 32'd0, 8'h5A, 8'h00, 8'h00);

        tick();
        tick();
        chk("scoreboard_drained", expQ.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dig_out_port.md
DIG_OUT_PORT -- requirements
Module: dig_out_port

Interface
REQ-001 Parameter REGION, default 8'h02: iADR[31:24] value that selects this block.
REQ-002 Parameter OFS_A, default 8'h00: iADR[7:0] offset of output register A.
REQ-003 Parameter OFS_B, default 8'h10: iADR[7:0] offset of output register B.
REQ-004 Parameter OFS_C, default 8'h20: iADR[7:0] offset of output register C.
REQ-005 iCLK  in  1: single clock; all state SHALL update on its rising edge.
REQ-006 iRST  in  1: reset, asynchronous, active-low.
REQ-007 iADR  in  32: bus byte address.
REQ-008 iDAT  in  32: write data; only bits [7:0] are used.
REQ-009 oDAT  out 32: read data.
REQ-010 iWE   in  1: 1 = write, 0 = read.
REQ-011 iSTB  in  1: raw bus strobe, not yet address-decoded.
REQ-012 oACK  out 1: transfer acknowledge.
REQ-013 oDOUTA/oDOUTB/oDOUTC  out 8 each: parallel outputs, driven directly from registers A/B/C.

Function
REQ-014 Block select SHALL be combinational: sel = iSTB AND (iADR[31:24] == REGION).
REQ-015 Register hit SHALL decode iADR[7:0] against OFS_A/B/C exactly.
  - iADR[23:8] is ignored, so the register map aliases across the region.
  - Any other offset is unmapped.
REQ-016 Accept condition: sel = 1 and oACK = 0 at a rising edge.
REQ-017 On accept, oACK SHALL be 1 for exactly the next cycle, then return to 0.
  - A strobe held high therefore yields an ack every second cycle.
  - Each ack is one accepted transfer.
REQ-018 Accepted write with a register hit SHALL load iDAT[7:0] into that register at the accepting edge.
  - iDAT[31:8] is ignored.
REQ-019 Accepted read with a register hit SHALL register {24'h0, reg} into oDAT at the accepting edge.
  - oDAT holds that value exactly while oACK = 1.
REQ-020 oDAT SHALL be 32'h0 in every cycle where oACK = 0, and for write acks.
REQ-021 Unmapped offset inside the region: still acknowledged; write ignored; read returns 32'h0.
REQ-022 iSTB with iADR[31:24] != REGION: no ack, no register change, oDAT = 0.
REQ-023 iWE, iADR and iDAT SHALL be sampled only at the accepting edge; changes at other times have no effect.
REQ-024 A read accepted at the same edge as nothing else returns the register value as it was before that edge; reads and writes never overlap because one transfer is accepted per edge.
REQ-025 oDOUTx SHALL change only at a write-accept edge or at reset, with no combinational path from bus inputs.

Reset
REQ-026 iRST = 0 SHALL immediately, without waiting for a clock edge, force:
  - registers A/B/C = 8'h00 (so oDOUTA/B/C = 8'h00);
  - oACK = 0;
  - oDAT = 32'h0.
REQ-027 Reset asserted mid-transfer SHALL abort it: no ack, no register update.
  - The first accept can occur at the first rising edge after iRST returns to 1.

Verification
REQ-028 Release reset; no strobe -> oDOUTA/B/C = 00, oACK = 0, oDAT = 0.
REQ-029 One-cycle write strobes, each followed by an idle cycle:
  - 0x0200_0000 data 0x12, then 0x0200_0010 data 0x34, then 0x0200_0020 data 0x56;
  - each -> one-cycle oACK one cycle later;
  - oDOUTA = 12, oDOUTB = 34, oDOUTC = 56 after the respective accept edges.
REQ-030 One-cycle read strobes at 0x0200_0000 / 0x0200_0010 / 0x0200_0020 -> oDAT = 0x12 / 0x34 / 0x56 during the ack cycle, 0 otherwise; oDOUTx unchanged.
REQ-031 Write 0xFF to 0x0100_0000 (other region) -> no ack, outputs unchanged; write 0x77 to 0x0200_0030 -> ack, outputs unchanged; read there -> ack, oDAT = 0.
REQ-032 Strobe held high for 4 cycles writing 0xAA to 0x0200_0000 -> oACK pattern 0,1,0,1; oDOUTA = AA.
REQ-033 Assert iRST between clock edges while a write strobe is active -> oACK and all outputs go to 0 immediately; register not written.
